// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller:
// funct3 codes, FSM states, store lane helpers.
package dmem_pkg;

  localparam int unsigned TIMEOUT_DEF = 15;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic op_legal(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~a[0];
      F3_W:        ok = (a == 2'b00);
      default:     ok = 1'b0;
    endcase
    // unsigned stores do not exist
    if (we && f3[2]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] store_be(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      (f3[1:0] == 2'b00): be = 4'b0001 << a;
      (f3[1:0] == 2'b01): be = a[1] ? 4'b1100 : 4'b0011;
      default:            be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] d;
    d = wd;
    unique case (1'b1)
      (f3[1:0] == 2'b00): d = {4{wd[7:0]}};
      (f3[1:0] == 2'b01): d = {2{wd[15:0]}};
      default:            d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word
// and sign- or zero-extends it.
module load_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[7:0];
    unique case (addr_lo)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = 32'd0;
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_W:    result = word;
      F3_BU:   result = {24'd0, b};
      F3_HU:   result = {16'd0, h};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store unit bus master: one outstanding op,
// stalls the pipeline until the bus completes or times out.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        d_req_o,
  output logic [31:0] d_addr_o,
  output logic [3:0]  d_we_o,
  output logic [31:0] d_wdata_o,
  input  logic        d_gnt_i,
  input  logic        d_rvalid_i,
  input  logic [31:0] d_rdata_i
);

  localparam logic [3:0] TO = 4'(TIMEOUT);

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  cnt_q;
  logic        err_q;
  logic        mis_q;

  logic        legal;
  logic        accept;
  logic        illegal;
  logic        capture;
  logic        tmo_hit;
  logic [31:0] aligned;

  assign legal = op_legal(we_i, funct3_i, addr_i[1:0]);

  load_align u_align (
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .word    (d_rdata_i),
    .result  (aligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    d_req_o = 1'b0;
    accept  = 1'b0;
    illegal = 1'b0;
    capture = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_i && !rst_i) begin
          if (legal) begin
            accept  = 1'b1;
            stall_o = 1'b1;
            state_d = S_REQ;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        d_req_o = 1'b1;
        if (d_gnt_i) state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (d_rvalid_i) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == TO) begin
          tmo_hit = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= illegal;
      if (accept) begin
        we_q    <= we_i;
        f3_q    <= funct3_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
        cnt_q   <= 4'd1;
      end
      if (state_q == S_WAIT && !capture && !tmo_hit)
        cnt_q <= cnt_q + 4'd1;
      if (capture) rdata_q <= aligned;
      // a timed-out load completes with zero data
      if (tmo_hit) begin
        err_q   <= 1'b1;
        rdata_q <= 32'd0;
      end
    end
  end

  assign err_o      = done_o & err_q;
  assign rdata_o    = done_o ? rdata_q : 32'd0;
  assign misalign_o = mis_q;

  assign d_addr_o  = d_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
  assign d_we_o    = (d_req_o && we_q) ?
                     store_be(f3_q, addr_q[1:0]) : 4'b0000;
  assign d_wdata_o = (d_req_o && we_q) ?
                     store_data(f3_q, wdata_q) : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed table,
// reset corner case and randomized ops vs. a reference model.
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        stall_o, done_o, misalign_o, err_o, d_req_o;
  logic [31:0] rdata_o, d_addr_o, d_wdata_o;
  logic [3:0]  d_we_o;
  logic        d_gnt_i = 1'b0;
  logic        d_rvalid_i = 1'b0;
  logic [31:0] d_rdata_i = 32'd0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .funct3_i   (funct3_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .rdata_o    (rdata_o),
    .misalign_o (misalign_o),
    .err_o      (err_o),
    .d_req_o    (d_req_o),
    .d_addr_o   (d_addr_o),
    .d_we_o     (d_we_o),
    .d_wdata_o  (d_wdata_o),
    .d_gnt_i    (d_gnt_i),
    .d_rvalid_i (d_rvalid_i),
    .d_rdata_i  (d_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          gd;
    int          rd;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        mis;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, stall_o, 0);
    chk({tag, ".done"}, done_o, 0);
    chk({tag, ".rdata"}, rdata_o, 0);
    chk({tag, ".mis"}, misalign_o, 0);
    chk({tag, ".err"}, err_o, 0);
    chk({tag, ".dreq"}, d_req_o, 0);
    chk({tag, ".daddr"}, d_addr_o, 0);
    chk({tag, ".dwe"}, d_we_o, 0);
    chk({tag, ".dwd"}, d_wdata_o, 0);
  endtask

  // Reference model: rules stated as byte arithmetic.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_legal(input logic we,
                                   input logic [2:0] f3,
                                   input logic [31:0] a);
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
    if (we && f3 >= 3'd4) return 1'b0;
    return (a % m_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int mask;
    mask = (1 << m_size(f3)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                       input logic [31:0] wd);
    if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] w);
    logic [31:0] v;
    int sz;
    sz = m_size(f3);
    v = w >> (8 * (a % 4));
    if (sz == 4) return v;
    v = v & ((32'd1 << (8 * sz)) - 1);
    if (f3 < 3'd4 && v >= (32'd1 << (8 * sz - 1)))
      v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  task automatic run_op(input vec_t v, input logic noise);
    bit got;
    @(posedge clk); #1;
    req_i = 1'b1;
    we_i = v.we;
    funct3_i = v.f3;
    addr_i = v.addr;
    wdata_i = v.wdata;
    d_gnt_i = 1'b0;
    d_rvalid_i = 1'b0;
    @(negedge clk);
    chk("stall_acc", stall_o, {31'd0, ~v.mis});
    chk("dreq_acc", d_req_o, 0);
    if (v.mis) begin
      @(posedge clk); #1;
      req_i = 1'b0;
      @(negedge clk);
      chk("misalign", misalign_o, 1);
      chk("mis_stall", stall_o, 0);
      chk("mis_dreq", d_req_o, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_pulse", misalign_o, 0);
      chk("mis_dreq2", d_req_o, 0);
      return;
    end
    for (int i = 0; i <= v.gd; i++) begin
      @(posedge clk); #1;
      d_gnt_i = (i == v.gd);
      d_rvalid_i = noise && (i == v.gd) && !v.we;
      d_rdata_i = $urandom;
      @(negedge clk);
      chk("dreq", d_req_o, 1);
      chk("daddr", d_addr_o, {v.addr[31:2], 2'b00});
      chk("dwe", d_we_o, v.we ? v.be : 4'd0);
      if (v.we) chk("dwdata", d_wdata_o, v.ewd);
      chk("stall_req", stall_o, 1);
      chk("done_req", done_o, 0);
    end
    if (!v.we) begin
      got = 1'b0;
      for (int k = 1; k <= TO && !got; k++) begin
        @(posedge clk); #1;
        d_gnt_i = 1'b0;
        d_rvalid_i = (k == v.rd);
        d_rdata_i = (k == v.rd) ? v.rword : $urandom;
        got = (k == v.rd);
        @(negedge clk);
        chk("stall_wait", stall_o, 1);
        chk("done_wait", done_o, 0);
        chk("dreq_wait", d_req_o, 0);
      end
    end
    @(posedge clk); #1;
    d_gnt_i = 1'b0;
    d_rvalid_i = noise;
    d_rdata_i = $urandom;
    @(negedge clk);
    chk("done", done_o, 1);
    chk("err", err_o, {31'd0, v.err});
    chk("rdata", rdata_o, v.we ? 32'd0 : v.erd);
    chk("stall_done", stall_o, 0);
    chk("dreq_done", d_req_o, 0);
    @(posedge clk); #1;
    req_i = 1'b0;
    d_rvalid_i = 1'b0;
    @(negedge clk);
    chk("done_after", done_o, 0);
    chk("dreq_after", d_req_o, 0);
    chk("stall_after", stall_o, 0);
  endtask

  initial begin
    vec_t r;
    vecs[0]  = '{1, 3'd0, 32'h103, 32'hA5, 0, 0, 0,
                 4'b1000, 32'hA5A5A5A5, 0, 0, 0};
    vecs[1]  = '{0, 3'd1, 32'h102, 0, 32'h80011234, 0, 3,
                 0, 0, 32'hFFFF8001, 0, 0};
    vecs[2]  = '{0, 3'd2, 32'h101, 0, 0, 0, 1,
                 0, 0, 0, 1, 0};
    vecs[3]  = '{0, 3'd4, 32'h100, 0, 32'h12345678, 0, 15,
                 0, 0, 0, 0, 1};
    vecs[4]  = '{1, 3'd2, 32'h200, 32'hDEADBEEF, 0, 5, 0,
                 4'b1111, 32'hDEADBEEF, 0, 0, 0};
    vecs[5]  = '{1, 3'd1, 32'h2, 32'h1234ABCD, 0, 1, 0,
                 4'b1100, 32'hABCDABCD, 0, 0, 0};
    vecs[6]  = '{0, 3'd0, 32'h1, 0, 32'h00008000, 0, 1,
                 0, 0, 32'hFFFFFF80, 0, 0};
    vecs[7]  = '{0, 3'd5, 32'h0, 0, 32'h1234F00D, 2, 4,
                 0, 0, 32'h0000F00D, 0, 0};
    vecs[8]  = '{0, 3'd2, 32'h10, 0, 32'hCAFEBABE, 0, 2,
                 0, 0, 32'hCAFEBABE, 0, 0};
    vecs[9]  = '{1, 3'd4, 32'h0, 32'h11, 0, 0, 0,
                 0, 0, 0, 1, 0};
    vecs[10] = '{0, 3'd3, 32'h0, 0, 0, 0, 1,
                 0, 0, 0, 1, 0};
    vecs[11] = '{0, 3'd0, 32'h2, 0, 32'h007F0000, 0, 1,
                 0, 0, 32'h0000007F, 0, 0};
    vecs[12] = '{0, 3'd1, 32'h1, 0, 0, 0, 1,
                 0, 0, 0, 1, 0};
    vecs[13] = '{0, 3'd4, 32'h3, 0, 32'hAB000000, 1, 1,
                 0, 0, 32'h000000AB, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk_zero("idle");

    foreach (vecs[i]) run_op(vecs[i], 1'b0);

    // reset while waiting for read data; late data ignored
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'd2;
    addr_i = 32'h40;
    @(posedge clk); #1;
    d_gnt_i = 1'b1;
    @(posedge clk); #1;
    d_gnt_i = 1'b0;
    @(negedge clk);
    chk("rst_wait_stall", stall_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    d_rvalid_i = 1'b1;
    d_rdata_i = 32'h55AA55AA;
    @(negedge clk);
    chk_zero("rst_mid");
    @(posedge clk); #1;
    d_rvalid_i = 1'b0;
    @(negedge clk);
    chk_zero("rst_late");
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_nodone", done_o, 0);

    for (int n = 0; n < 80; n++) begin
      r.we    = 1'($urandom_range(0, 1));
      r.f3    = 3'($urandom_range(0, 7));
      r.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) r.addr[1:0] = 2'b00;
      r.wdata = $urandom;
      r.rword = $urandom;
      r.gd    = $urandom_range(0, 3);
      r.rd    = $urandom_range(1, TO + 1);
      r.mis   = ~m_legal(r.we, r.f3, r.addr);
      r.be    = r.mis ? 4'd0 : m_be(r.f3, r.addr);
      r.ewd   = m_wd(r.f3, r.wdata);
      r.err   = !r.we && !r.mis && (r.rd > TO);
      r.erd   = (r.err || r.mis) ? 32'd0 :
                m_rd(r.f3, r.addr, r.rword);
      run_op(r, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the load response wait limit in cycles (range 1..15).
REQ-002 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 req_i  in  1  pipeline memory-op valid; held stable while stall_o=1.
REQ-005 we_i  in  1  1=store, 0=load.
REQ-006 funct3_i  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr_i  in  32  byte address.
REQ-008 wdata_i  in  32  store data, right-aligned.
REQ-009 stall_o  out  1  freeze pipeline while the op is outstanding.
REQ-010 done_o  out  1  one-cycle completion pulse.
REQ-011 rdata_o  out  32  load result, valid only while done_o=1, else 0.
REQ-012 misalign_o  out  1  one-cycle pulse: misaligned address or unsupported funct3.
REQ-013 err_o  out  1  one-cycle pulse: load response timeout.
REQ-014 d_req_o  out  1  bus request; d_addr_o  out  32  word address, [1:0]=00; d_we_o  out  4  byte write enables; d_wdata_o  out  32  lane-replicated store data.
REQ-015 d_gnt_i  in  1  bus accepts request this cycle; d_rvalid_i  in  1  read data valid; d_rdata_i  in  32  read word.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-017 IDLE, req_i=1, legal op: latch we/funct3/addr/wdata, go REQ; stall_o=1 same cycle (combinational).
REQ-018 Illegal op (H with addr[0]=1; W with addr[1:0]!=00; funct3 011/110/111; store funct3 1xx): misalign_o pulse next cycle, no bus request, stay IDLE, stall_o=0.
REQ-019 REQ: d_req_o=1 with latched fields held until d_gnt_i=1; store+gnt -> DONE; load+gnt -> WAIT.
REQ-020 Store byte enables: B -> 0001<<addr[1:0]; H -> 0011 (addr[1]=0) or 1100; W -> 1111; loads drive d_we_o=0000.
REQ-021 d_wdata_o: B byte replicated x4, H halfword replicated x2, W as-is.
REQ-022 WAIT: d_rvalid_i=1 -> capture extracted data, go DONE; d_rvalid_i is ignored in the gnt cycle itself.
REQ-023 Load extraction: select byte/half by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend.
REQ-024 WAIT counter SHALL count cycles from 1; reaching TIMEOUT without rvalid -> DONE with err_o=1, rdata_o=0.
REQ-025 DONE: done_o=1, stall_o=0, unconditionally -> IDLE; req_i in DONE is ignored.
REQ-026 Minimum latency: store with immediate gnt = 2 cycles from acceptance to done_o; load = 3 cycles.
REQ-027 d_rvalid_i outside WAIT SHALL be ignored.

Reset
REQ-028 rst_i=1 at an edge SHALL force IDLE, clear counter/latches, and drive all outputs 0, including mid-transaction.
REQ-029 A response arriving after reset SHALL be discarded.

Structure
REQ-030 Package dmem_pkg SHALL hold funct3 encodings, state encodings and the TIMEOUT default.
REQ-031 Load extraction/extension SHALL be a combinational sub-module load_align (funct3, addr[1:0], word -> 32-bit result).
REQ-032 Estimated size: 150-300 lines.

Verification
REQ-033 SB addr 0x103, wdata 0xA5, gnt immediate -> d_we_o=1000, d_wdata_o=0xA5A5A5A5, done_o 2 cycles after acceptance.
REQ-034 LH addr 0x102, rvalid 3 cycles after gnt, d_rdata_i=0x8001_1234 -> rdata_o=0xFFFF8001 with done_o.
REQ-035 LW addr 0x101 -> misalign_o pulse, d_req_o stays 0, stall_o 0.
REQ-036 LBU, no rvalid, TIMEOUT=4 -> err_o and done_o together after 4 WAIT cycles, rdata_o=0.
REQ-037 rst_i in WAIT, then late rvalid -> IDLE, all outputs 0, no done_o.
REQ-038 SW with d_gnt_i low 5 cycles -> d_req_o and fields stable, stall_o=1 throughout, d_we_o=1111.
